alu_issue_ctrl: RTL
===================

// Module: alu_issue_ctrl
// PURPOSE
//  Multi-cycle execute controller that drives the combinational ALU.
//  - Accepts one MIPS R-type instruction word at a time over a valid/ready handshake.
//  - Reads rs/rt from the register file, decodes funct into the ALU operation code and drives ALU operands.
//  - Sequences the ALU shift-by-one ops shamt times, then issues a single writeback.
// PARAMETERS
//  XLEN   32  datapath width; fixed at 32, not to be overridden
//  REG_AW 5   register address width
// PORTS
//  clk        in   1     clock; all state updates on the rising edge
//  reset      in   1     asynchronous, active-high reset
//  instr_valid in  1     instruction word present
//  instr_ready out 1     controller can accept; high only in IDLE
//  instr      in   32    opcode[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6] funct[5:0]
//  rs_addr    out  5     regfile read address A, registered
//  rt_addr    out  5     regfile read address B, registered
//  rs_data    in   32    combinational read of rs_addr
//  rt_data    in   32    combinational read of rt_addr
//  alu_op     out  6     ALU operation (funct encoding)
//  alu_a      out  32    ALU operand a
//  alu_b      out  32    ALU operand b
//  alu_result in   32    ALU Result
//  alu_zero   in   1     ALU zeroFlag
//  wb_valid   out  1     one-cycle writeback strobe
//  wb_addr    out  5     destination register (rd)
//  wb_data    out  32    writeback value
//  zero_flag  out  1     sticky zero status from the last ADD/SUB
//  illegal    out  1     one-cycle pulse when an instruction is rejected
//  busy       out  1     high in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE; instr_ready=1; all other outputs, operand regs and counters are 0.
//   Reset mid-operation aborts the instruction; no wb_valid is issued.
//  FSM: IDLE -> READ -> EXEC -> [SHIFT]* -> WB -> IDLE
//   IDLE:  On instr_valid&&instr_ready, latch instr and set rs_addr/rt_addr.
//          Decode check: opcode!=0, or funct not in the supported set -> pulse illegal, stay in IDLE.
//          Supported funct: MOVN, MOVZ, AND, OR, XOR, NOR, ADDU, SUBU, ADD, SUB, SLL, SLLV, SRL, SRLV, SRA, SRAV, SLT, SLTU.
//   READ:  Latch opA=rs_data and opB=rt_data.
//   EXEC:  alu_op=funct.
//          Default operands: alu_a=opA, alu_b=opB.
//          SRA operands: alu_a=opB.
//          Latch alu_result into res.
//          ADD/SUB (100000/100010): zero_flag<=alu_zero.
//          SLL/SRL/SRA with shamt>1: load cnt=shamt-1 and go to SHIFT.
//          SLL/SRL/SRA with shamt==0: res=opB; no ALU result is used.
//   SHIFT: Feed res back as the shifted operand (alu_b for SLL/SRL, alu_a for SRA).
//          Latch alu_result and decrement cnt; when cnt==0 go to WB.
//   WB:    wb_valid=1 for one cycle with wb_addr=rd and wb_data=res.
//          Suppress the write (wb_valid stays 0) when rd==0.
//          MOVN: suppress when opB==0. MOVZ: suppress when opB!=0.
//  Latency: accept at cycle 0; wb_valid at cycle 3 for non-iterative ops; shifts take 3+max(shamt-1,0).
//  instr_valid while busy is ignored; it is never dropped silently once accepted.
//  alu_op/alu_a/alu_b hold their last value outside EXEC/SHIFT.
// CONFIGURATION
//  LEAD_COUNT_EN defined:
//   opcode 011100 (SPECIAL2) with funct 100001 (CLO) / 100000 (CLZ) is legal.
//   EXEC branches to COUNT, which scans opA from bit 31 down, one bit per cycle.
//   Scan stops on the first bit !=1 (CLO) or !=0 (CLZ), or after 32 bits.
//   res = count (0..32); then WB.
//  LEAD_COUNT_EN undefined: SPECIAL2 is illegal (illegal pulse, no writeback).
// STRUCTURE
//  Package alu_ctrl_pkg: opcode/funct localparams, state encoding, is_shift_imm() helper.
//  Sub-module lead_count_unit (start, operand, mode, done, count[5:0]) implements COUNT.
//   It is instantiated only under LEAD_COUNT_EN.
// TESTING
//  1. ADD rs=5, rt=-5 -> wb_valid at cycle 3, wb_data=0, zero_flag=1.
//  2. SLL rt=0x0000_0001, shamt=4 -> wb_data=0x0000_0010; 3 SHIFT cycles; shamt=0 -> wb_data=rt.
//  3. MOVZ rt=7 -> no wb_valid. MOVN rt=7, rs=0xABCD -> wb_data=0xABCD.
//  4. opcode=0x08, or funct=0x3F -> illegal pulse, no wb_valid, instr_ready high next cycle.
//  5. reset asserted during SHIFT -> all outputs 0 immediately, IDLE, no writeback.
//  6. LEAD_COUNT_EN: CLZ 0x00F0_0000 -> 8; CLO 0xFFFF_FFFF -> 32; CLZ 0x8000_0000 -> 0.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared opcode/funct encodings, FSM state type and decode helpers for alu_issue_ctrl.
package alu_ctrl_pkg;

    localparam logic [5:0] OP_SPECIAL  = 6'b000000;
    localparam logic [5:0] OP_SPECIAL2 = 6'b011100;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_MOVZ = 6'b001010;
    localparam logic [5:0] FN_MOVN = 6'b001011;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    // SPECIAL2 count-leading functs (share encodings with ADD/ADDU)
    localparam logic [5:0] FN_CLZ  = 6'b100000;
    localparam logic [5:0] FN_CLO  = 6'b100001;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_EXEC  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_COUNT = 3'd4,
        ST_WB    = 3'd5
    } state_t;

    function automatic logic is_shift_imm(input logic [5:0] funct);
        return (funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA);
    endfunction

    function automatic logic is_special_funct(input logic [5:0] funct);
        case (funct)
            FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
            FN_MOVZ, FN_MOVN, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
            FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lead_count_unit.sv
// Bit-serial leading ones/zeros counter: scans the operand from the MSB, one bit per cycle.
module lead_count_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [XLEN-1:0] operand,
    input  logic            mode,
    output logic            done,
    output logic [5:0]      count
);

    logic            r_active;
    logic [XLEN-1:0] r_scan;
    logic [5:0]      r_count;
    logic            w_hit;

    // mode=1 counts leading ones, mode=0 counts leading zeros
    assign w_hit = (r_scan[XLEN-1] == mode);
    assign done  = r_active && (!w_hit || (r_count == 6'(XLEN)));
    assign count = r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_active <= 1'b0;
            r_scan   <= '0;
            r_count  <= '0;
        end else if (start) begin
            r_active <= 1'b1;
            r_scan   <= operand;
            r_count  <= '0;
        end else if (r_active) begin
            if (done) begin
                r_active <= 1'b0;
            end else begin
                r_scan  <= r_scan << 1;
                r_count <= r_count + 6'd1;
            end
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle execute controller for MIPS R-type ops driving an external combinational ALU.
// Define LEAD_COUNT_EN to add SPECIAL2 CLO/CLZ via lead_count_unit.
module alu_issue_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    output logic [REG_AW-1:0] rs_addr,
    output logic [REG_AW-1:0] rt_addr,
    input  logic [XLEN-1:0]   rs_data,
    input  logic [XLEN-1:0]   rt_data,
    output logic [5:0]        alu_op,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    input  logic [XLEN-1:0]   alu_result,
    input  logic              alu_zero,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_addr,
    output logic [XLEN-1:0]   wb_data,
    output logic              zero_flag,
    output logic              illegal,
    output logic              busy
);

    state_t            r_state;
    state_t            w_state_next;
    logic [5:0]        r_opcode;
    logic [5:0]        r_funct;
    logic [4:0]        r_shamt;
    logic [REG_AW-1:0] r_rd;
    logic [REG_AW-1:0] r_rs_addr;
    logic [REG_AW-1:0] r_rt_addr;
    logic [XLEN-1:0]   r_op_a;
    logic [XLEN-1:0]   r_op_b;
    logic [XLEN-1:0]   r_res;
    logic [4:0]        r_cnt;
    logic [5:0]        r_alu_op;
    logic [XLEN-1:0]   r_alu_a;
    logic [XLEN-1:0]   r_alu_b;
    logic              r_zero_flag;
    logic              r_illegal;

    logic              w_accept;
    logic              w_legal;
    logic              w_special;
    logic              w_shift_imm;
    logic              w_is_sra;
    logic              w_is_addsub;
    logic              w_wb_en;
    logic              w_is_count;
    logic              w_lc_done;
    logic [5:0]        w_lc_count;

    assign w_accept    = instr_valid && (r_state == ST_IDLE);
    assign w_special   = (r_opcode == OP_SPECIAL);
    assign w_shift_imm = w_special && is_shift_imm(r_funct);
    assign w_is_sra    = w_special && (r_funct == FN_SRA);
    assign w_is_addsub = w_special && ((r_funct == FN_ADD) || (r_funct == FN_SUB));

    // Conditional moves decide on rt; rd==0 never writes
    assign w_wb_en = (r_rd != '0)
                   && !(w_special && (r_funct == FN_MOVN) && (r_op_b == '0))
                   && !(w_special && (r_funct == FN_MOVZ) && (r_op_b != '0));

    always_comb begin
        w_legal = (instr[31:26] == OP_SPECIAL) && is_special_funct(instr[5:0]);
`ifdef LEAD_COUNT_EN
        if ((instr[31:26] == OP_SPECIAL2) &&
            ((instr[5:0] == FN_CLZ) || (instr[5:0] == FN_CLO)))
            w_legal = 1'b1;
`endif
    end

`ifdef LEAD_COUNT_EN
    logic w_lc_start;

    assign w_is_count = (r_opcode == OP_SPECIAL2);
    assign w_lc_start = (r_state == ST_EXEC) && w_is_count;

    lead_count_unit #(
        .XLEN (XLEN)
    ) u_lead_count (
        .clk     (clk),
        .reset   (reset),
        .start   (w_lc_start),
        .operand (r_op_a),
        .mode    (r_funct[0]),
        .done    (w_lc_done),
        .count   (w_lc_count)
    );
`else
    assign w_is_count = 1'b0;
    assign w_lc_done  = 1'b0;
    assign w_lc_count = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept && w_legal) w_state_next = ST_READ;
            ST_READ:  w_state_next = ST_EXEC;
            ST_EXEC: begin
                if (w_is_count)
                    w_state_next = ST_COUNT;
                else if (w_shift_imm && (r_shamt > 5'd1))
                    w_state_next = ST_SHIFT;
                else
                    w_state_next = ST_WB;
            end
            // r_cnt==1 here means this cycle's decrement reaches zero
            ST_SHIFT: if (r_cnt == 5'd1) w_state_next = ST_WB;
            ST_COUNT: if (w_lc_done) w_state_next = ST_WB;
            ST_WB:    w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_opcode    <= '0;
            r_funct     <= '0;
            r_shamt     <= '0;
            r_rd        <= '0;
            r_rs_addr   <= '0;
            r_rt_addr   <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_res       <= '0;
            r_cnt       <= '0;
            r_alu_op    <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_zero_flag <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_illegal <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_opcode  <= instr[31:26];
                        r_rs_addr <= instr[25:21];
                        r_rt_addr <= instr[20:16];
                        r_rd      <= instr[15:11];
                        r_shamt   <= instr[10:6];
                        r_funct   <= instr[5:0];
                        r_illegal <= !w_legal;
                    end
                end
                ST_READ: begin
                    // ALU operands are registered so they are stable throughout EXEC
                    r_op_a   <= rs_data;
                    r_op_b   <= rt_data;
                    r_alu_op <= r_funct;
                    r_alu_a  <= w_is_sra ? rt_data : rs_data;
                    r_alu_b  <= rt_data;
                end
                ST_EXEC: begin
                    r_res <= (w_shift_imm && (r_shamt == 5'd0)) ? r_op_b : alu_result;
                    if (w_is_addsub)
                        r_zero_flag <= alu_zero;
                    if (w_shift_imm && (r_shamt > 5'd1)) begin
                        r_cnt <= r_shamt - 5'd1;
                        if (w_is_sra)
                            r_alu_a <= alu_result;
                        else
                            r_alu_b <= alu_result;
                    end
                end
                ST_SHIFT: begin
                    r_res <= alu_result;
                    r_cnt <= r_cnt - 5'd1;
                    if (w_is_sra)
                        r_alu_a <= alu_result;
                    else
                        r_alu_b <= alu_result;
                end
                ST_COUNT: begin
                    if (w_lc_done)
                        r_res <= {{(XLEN-6){1'b0}}, w_lc_count};
                end
                default: ;
            endcase
        end
    end

    assign instr_ready = (r_state == ST_IDLE);
    assign busy        = (r_state != ST_IDLE);
    assign rs_addr     = r_rs_addr;
    assign rt_addr     = r_rt_addr;
    assign alu_op      = r_alu_op;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign wb_valid    = (r_state == ST_WB) && w_wb_en;
    assign wb_addr     = r_rd;
    assign wb_data     = r_res;
    assign zero_flag   = r_zero_flag;
    assign illegal     = r_illegal;

endmodule
